// File: rtl/t03_multicycle_control_unit.sv
// rtl/t03_multicycle_control_unit.sv - registered multi-cycle RV32I control unit with memory-ack wait and timeout
// Optional illegal-instruction trap output enabled by T03_ILLEGAL_TRAP_EN.
module t03_multicycle_control_unit #(
  parameter int ALU_OP_W  = 4,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                instr_valid,
  input  logic [31:0]         instruction,
  output logic                instr_ready,
  input  logic                mem_ack,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          branch_type,
  output logic                reg_write_en,
  output logic                alu_mux_en,
  output logic                mem_to_reg,
  output logic                read_mem,
  output logic                write_mem,
  output logic                store_byte,
  output logic                load_byte,
  output logic                read_next_pc,
  output logic                pc_add_write_value,
  output logic                slt,
  output logic                u,
  output logic                pc_en,
  output logic                busy,
  output logic                timeout_err
`ifdef T03_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_instr
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_WB = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR  = 4'd3,
                         ALU_AND = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_IMM = 4'd8;

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] bt;
    logic rw, mux, m2r, rd, wr, sb, lb, rnp, pca, slt, u;
  } ctrl_t;

  ctrl_t                dec, ctrl_q, ctrl_d;
  logic                 legal;
  logic [1:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 tmo_q, tmo_d;
`ifdef T03_ILLEGAL_TRAP_EN
  logic                 ill_q, ill_d;
`endif

  logic [6:0] op;
  logic [2:0] f3;
  logic       i30;
  assign op  = instruction[6:0];
  assign f3  = instruction[14:12];
  assign i30 = instruction[30];
  wire unused_bits = &{1'b0, instruction[31], instruction[29:15], instruction[11:7]};

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (op)
      7'b0110011: begin
        dec.rw = 1'b1;
        case ({i30, f3})
          4'b0000: dec.alu = ALU_ADD;
          4'b1000: dec.alu = ALU_SUB;
          4'b0001: dec.alu = ALU_SLL;
          4'b0010: begin dec.alu = ALU_SUB; dec.slt = 1'b1; end
          4'b0011: begin dec.alu = ALU_SUB; dec.slt = 1'b1; dec.u = 1'b1; end
          4'b0100: dec.alu = ALU_XOR;
          4'b0101: dec.alu = ALU_SRL;
          4'b1101: dec.alu = ALU_SRA;
          4'b0110: dec.alu = ALU_OR;
          4'b0111: dec.alu = ALU_AND;
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.rw  = 1'b1;
        dec.mux = 1'b1;
        // bit 30 is immediate data except for the shift-immediates
        case (f3)
          3'b000: dec.alu = ALU_ADD;
          3'b010: begin dec.alu = ALU_SUB; dec.slt = 1'b1; end
          3'b011: begin dec.alu = ALU_SUB; dec.slt = 1'b1; dec.u = 1'b1; end
          3'b100: dec.alu = ALU_XOR;
          3'b110: dec.alu = ALU_OR;
          3'b111: dec.alu = ALU_AND;
          3'b001: if (i30) legal = 1'b0; else dec.alu = ALU_SLL;
          default: dec.alu = i30 ? ALU_SRA : ALU_SRL;
        endcase
      end
      7'b0000011: begin
        dec.rw = 1'b1; dec.mux = 1'b1; dec.m2r = 1'b1; dec.rd = 1'b1;
        dec.lb = (f3 == 3'b000);
        if (f3 != 3'b000 && f3 != 3'b010) legal = 1'b0;
      end
      7'b0100011: begin
        dec.mux = 1'b1; dec.wr = 1'b1;
        dec.sb  = (f3 == 3'b000);
        if (f3 != 3'b000 && f3 != 3'b010) legal = 1'b0;
      end
      7'b0110111: begin dec.rw = 1'b1; dec.mux = 1'b1; dec.alu = ALU_IMM; end
      7'b0010111: begin dec.rw = 1'b1; dec.mux = 1'b1; dec.rnp = 1'b1; dec.pca = 1'b1; end
      7'b1100011: begin
        dec.alu = ALU_SUB;
        case (f3)
          3'b000: dec.bt = 3'd1;
          3'b001: dec.bt = 3'd2;
          3'b100: dec.bt = 3'd3;
          3'b101: dec.bt = 3'd4;
          3'b110: begin dec.bt = 3'd5; dec.u = 1'b1; end
          3'b111: begin dec.bt = 3'd6; dec.u = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      7'b1101111: begin dec.rw = 1'b1; dec.bt = 3'd7; dec.rnp = 1'b1; end
      7'b1100111: begin
        dec.rw = 1'b1; dec.mux = 1'b1; dec.bt = 3'd7; dec.rnp = 1'b1; dec.pca = 1'b1;
        if (f3 != 3'b000) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) dec = '0;
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + TIMEOUT_W'(1);
    tmo_d   = 1'b0;
`ifdef T03_ILLEGAL_TRAP_EN
    ill_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (instr_valid) begin
        state_d = S_EXEC;
        ctrl_d  = dec;
        cnt_d   = '0;
`ifdef T03_ILLEGAL_TRAP_EN
        ill_d   = !legal;
`endif
      end
      S_EXEC: begin
`ifdef T03_ILLEGAL_TRAP_EN
        if (ill_q) begin
          state_d = S_IDLE;
          ctrl_d  = '0;
        end else
`endif
        state_d = (ctrl_q.rd || ctrl_q.wr) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // an ack arriving on the final counted cycle still completes the access
        if (mem_ack) begin
          state_d = S_WB;
        end else if (cnt_inc == '1) begin
          state_d = S_IDLE;
          ctrl_d  = '0;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        ctrl_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`ifdef T03_ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`ifdef T03_ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

  assign instr_ready        = (state_q == S_IDLE);
  assign busy               = (state_q != S_IDLE);
  assign alu_op             = ALU_OP_W'(ctrl_q.alu);
  assign branch_type        = ctrl_q.bt;
  assign alu_mux_en         = ctrl_q.mux;
  assign mem_to_reg         = ctrl_q.m2r;
  assign store_byte         = ctrl_q.sb;
  assign load_byte          = ctrl_q.lb;
  assign read_next_pc       = ctrl_q.rnp;
  assign pc_add_write_value = ctrl_q.pca;
  assign slt                = ctrl_q.slt;
  assign u                  = ctrl_q.u;
  assign read_mem           = (state_q == S_MEM) && ctrl_q.rd;
  assign write_mem          = (state_q == S_MEM) && ctrl_q.wr;
  assign pc_en              = (state_q == S_WB);
  assign reg_write_en       = (state_q == S_WB) && ctrl_q.rw;
  assign timeout_err        = tmo_q;
`ifdef T03_ILLEGAL_TRAP_EN
  assign illegal_instr      = (state_q == S_EXEC) && ill_q;
`endif

endmodule

// File: tb/tb_t03_multicycle_control_unit.sv
// tb/tb_t03_multicycle_control_unit.sv - table-driven directed bench for t03_multicycle_control_unit
module tb_t03_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        nRst, instr_valid, mem_ack;
  logic [31:0] instruction;
  logic        instr_ready, reg_write_en, alu_mux_en, mem_to_reg, read_mem, write_mem;
  logic        store_byte, load_byte, read_next_pc, pc_add_write_value, slt, u;
  logic        pc_en, busy, timeout_err;
  logic [3:0]  alu_op;
  logic [2:0]  branch_type;
`ifdef T03_ILLEGAL_TRAP_EN
  logic        illegal_instr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  t03_multicycle_control_unit #(.ALU_OP_W(4), .TIMEOUT_W(3)) dut (
    .clk(clk), .nRst(nRst), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .alu_op(alu_op), .branch_type(branch_type),
    .reg_write_en(reg_write_en), .alu_mux_en(alu_mux_en), .mem_to_reg(mem_to_reg),
    .read_mem(read_mem), .write_mem(write_mem), .store_byte(store_byte), .load_byte(load_byte),
    .read_next_pc(read_next_pc), .pc_add_write_value(pc_add_write_value), .slt(slt), .u(u),
    .pc_en(pc_en), .busy(busy), .timeout_err(timeout_err)
`ifdef T03_ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [14:0] ctrl;
    logic        rw;
  } vec_t;

  // {alu_op, branch_type, alu_mux_en, mem_to_reg, read_next_pc, pc_add_write_value, slt, u, store_byte, load_byte}
  function automatic logic [14:0] mkc(input logic [3:0] a, input logic [2:0] b, input logic mux,
                                      input logic rnp, input logic pca, input logic s, input logic uu);
    return {a, b, mux, 1'b0, rnp, pca, s, uu, 1'b0, 1'b0};
  endfunction

  function automatic logic [14:0] dut_ctrl();
    return {alu_op, branch_type, alu_mux_en, mem_to_reg, read_next_pc, pc_add_write_value,
            slt, u, store_byte, load_byte};
  endfunction

  function automatic logic [31:0] all_out();
    logic [31:0] v;
    v = 32'({alu_op, branch_type, reg_write_en, alu_mux_en, mem_to_reg, read_mem, write_mem,
             store_byte, load_byte, read_next_pc, pc_add_write_value, slt, u, pc_en, busy, timeout_err});
`ifdef T03_ILLEGAL_TRAP_EN
    v[31] = illegal_instr;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{"add",   32'h003100B3, mkc(4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1};
    vecs[1]  = '{"sub",   32'h403100B3, mkc(4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1};
    vecs[2]  = '{"sltu",  32'h003130B3, mkc(4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1};
    vecs[3]  = '{"sra",   32'h403150B3, mkc(4'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1};
    vecs[4]  = '{"srai",  32'h40315093, mkc(4'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1};
    vecs[5]  = '{"xori",  32'h00314093, mkc(4'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1};
    vecs[6]  = '{"slli",  32'h00311093, mkc(4'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1};
    vecs[7]  = '{"slti",  32'h00312093, mkc(4'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1};
    vecs[8]  = '{"lui",   32'h123450B7, mkc(4'd8, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1};
    vecs[9]  = '{"auipc", 32'h00001097, mkc(4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1};
    vecs[10] = '{"beq",   32'h00208063, mkc(4'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0};
    vecs[11] = '{"bgeu",  32'h0020F063, mkc(4'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0};
    vecs[12] = '{"bltu",  32'h0020E063, mkc(4'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0};
    vecs[13] = '{"jal",   32'h008000EF, mkc(4'd0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1};
    vecs[14] = '{"jalr",  32'h000080E7, mkc(4'd0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1};

    // reset held with a pending instruction
    nRst = 1'b0; instr_valid = 1'b1; instruction = 32'h003100B3; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", all_out(), 32'h0);
    check("reset ready", 32'(instr_ready), 32'h1);
    nRst = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    check("post-reset idle", all_out(), 32'h0);

    for (int i = 0; i < 15; i++) begin
      instr_valid = 1'b1; instruction = vecs[i].instr;
      check($sformatf("%s ready", vecs[i].name), 32'(instr_ready), 32'h1);
      @(negedge clk);
      instruction = 32'hFFFFFFFF;  // offered while busy, must be ignored
      check($sformatf("%s exec ctrl", vecs[i].name), 32'(dut_ctrl()), 32'(vecs[i].ctrl));
      check($sformatf("%s exec strobes", vecs[i].name), 32'({busy, instr_ready, pc_en, reg_write_en}), 32'b1000);
      @(negedge clk);
      instr_valid = 1'b0;
      check($sformatf("%s wb ctrl", vecs[i].name), 32'(dut_ctrl()), 32'(vecs[i].ctrl));
      check($sformatf("%s wb strobes", vecs[i].name), 32'({pc_en, reg_write_en}), 32'({1'b1, vecs[i].rw}));
      @(negedge clk);
      check($sformatf("%s back idle", vecs[i].name), all_out(), 32'h0);
      check($sformatf("%s next ready", vecs[i].name), 32'(instr_ready), 32'h1);
    end

    // LB, ack on the third MEM cycle
    instr_valid = 1'b1; instruction = 32'h00010083;
    @(negedge clk);
    instr_valid = 1'b0;
    check("lb exec ctrl", 32'(dut_ctrl()), 32'({4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    check("lb exec no read", 32'(read_mem), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("lb mem%0d", k), 32'({read_mem, load_byte, pc_en}), 32'b110);
      if (k == 2) mem_ack = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("lb wb", 32'({mem_to_reg, reg_write_en, pc_en, read_mem}), 32'b1110);
    @(negedge clk);
    check("lb done", 32'({instr_ready, busy}), 32'b10);

    // SW with ack held from IDLE: ack outside MEM is ignored
    instr_valid = 1'b1; instruction = 32'h00112023; mem_ack = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("sw exec", 32'({busy, write_mem, store_byte, alu_mux_en}), 32'b1001);
    @(negedge clk);
    check("sw mem", 32'({write_mem, pc_en}), 32'b10);
    @(negedge clk);
    mem_ack = 1'b0;
    check("sw wb", 32'({pc_en, reg_write_en, write_mem}), 32'b100);
    @(negedge clk);

    // SW timeout after 7 MEM cycles
    instr_valid = 1'b1; instruction = 32'h00112023;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("sw tmo mem%0d", k), 32'({write_mem, pc_en, reg_write_en, timeout_err}), 32'b1000);
    end
    @(negedge clk);
    check("sw tmo pulse", 32'({instr_ready, timeout_err, write_mem, pc_en, reg_write_en}), 32'b11000);
    check("sw tmo ctrl clear", 32'(dut_ctrl()), 32'h0);
    @(negedge clk);
    check("sw tmo pulse end", all_out(), 32'h0);

    // SB with ack on the final counted cycle: ack wins
    instr_valid = 1'b1; instruction = 32'h00110023;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    check("sb last mem", 32'({write_mem, store_byte}), 32'b11);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("sb ack wins", 32'({pc_en, timeout_err, reg_write_en}), 32'b100);
    @(negedge clk);
    check("sb idle", 32'({instr_ready, timeout_err}), 32'b10);

    // reset during MEM of LW
    instr_valid = 1'b1; instruction = 32'h00012083;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("lw mem before reset", 32'(read_mem), 32'h1);
    nRst = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    check("reset mid outputs", all_out(), 32'h0);
    check("reset mid ready", 32'(instr_ready), 32'h1);
    @(negedge clk);
    check("reset mid no wb", all_out(), 32'h0);

    // unrecognised key 0x0000007F
    instr_valid = 1'b1; instruction = 32'h0000007F;
    @(negedge clk);
    instr_valid = 1'b0;
`ifdef T03_ILLEGAL_TRAP_EN
    check("illegal pulse", 32'({illegal_instr, busy}), 32'b11);
    @(negedge clk);
    check("illegal no wb", 32'({instr_ready, pc_en, reg_write_en, illegal_instr}), 32'b1000);
`else
    check("nop exec ctrl", 32'(dut_ctrl()), 32'h0);
    check("nop exec busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("nop wb", 32'({pc_en, reg_write_en}), 32'b10);
    @(negedge clk);
    check("nop idle", 32'(instr_ready), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
